// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the three-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_NORMAL = 2'd0,
    ARB_DRAIN  = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_e;

  localparam int REQ_OCD   = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_FETCH = 2;
  localparam int NUM_REQ   = 3;
  localparam int BANK_DW   = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and dual-bank memory signals for mem_port_arbiter; slave is the arbiter side.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 12
);
  import mem_arb_pkg::*;

  logic                  ocd_lock;
  logic                  ocd_locked;
  logic                  ocd_req;
  logic                  data_req;
  logic                  fetch_req;
  logic [3:0]            ocd_we;
  logic [3:0]            data_we;
  logic [ADDR_WIDTH-1:0] ocd_addr;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [31:0]           ocd_wdata;
  logic [31:0]           data_wdata;
  logic                  ocd_ack;
  logic                  data_ack;
  logic                  fetch_ack;
  logic                  ocd_rvalid;
  logic                  data_rvalid;
  logic                  fetch_rvalid;
  logic [31:0]           rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [BANK_DW-1:0]    mem_din_high;
  logic [BANK_DW-1:0]    mem_din_low;
  logic [1:0]            mem_we_high;
  logic [1:0]            mem_we_low;
  logic [BANK_DW-1:0]    mem_dout_high;
  logic [BANK_DW-1:0]    mem_dout_low;

  modport slave (
    input  ocd_lock, ocd_req, data_req, fetch_req, ocd_we, data_we,
           ocd_addr, data_addr, fetch_addr, ocd_wdata, data_wdata,
           mem_dout_high, mem_dout_low,
    output ocd_locked, ocd_ack, data_ack, fetch_ack,
           ocd_rvalid, data_rvalid, fetch_rvalid, rdata,
           mem_addr, mem_din_high, mem_din_low, mem_we_high, mem_we_low
  );

  modport master (
    output ocd_lock, ocd_req, data_req, fetch_req, ocd_we, data_we,
           ocd_addr, data_addr, fetch_addr, ocd_wdata, data_wdata,
           mem_dout_high, mem_dout_low,
    input  ocd_locked, ocd_ack, data_ack, fetch_ack,
           ocd_rvalid, data_rvalid, fetch_rvalid, rdata,
           mem_addr, mem_din_high, mem_din_low, mem_we_high, mem_we_low
  );

endinterface

// File: rtl/mem_port_arbiter_prio_sel.sv
// One-hot priority select: ocd > data > fetch, with fetch lifted above data when promoted.
module mem_arb_prio_sel
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_promote_fetch,
  output logic [NUM_REQ-1:0] o_grant
);

  always_comb begin
    o_grant = '0;
    if (i_req[REQ_OCD]) begin
      o_grant[REQ_OCD] = 1'b1;
    end else if (i_promote_fetch && i_req[REQ_FETCH]) begin
      o_grant[REQ_FETCH] = 1'b1;
    end else if (i_req[REQ_DATA]) begin
      o_grant[REQ_DATA] = 1'b1;
    end else if (i_req[REQ_FETCH]) begin
      o_grant[REQ_FETCH] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for OCD/loader, data and fetch over two 16-bit banks.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  mem_port_arbiter_if.slave  bus
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  arb_state_e              r_state;
  arb_state_e              w_state_nxt;
  logic                    r_locked;
  logic [NUM_REQ-1:0]      r_rvalid_p1;
  logic [ADDR_WIDTH-1:0]   r_addr_last;
  logic [NUM_REQ-1:0]      w_req;
  logic [NUM_REQ-1:0]      w_req_elig;
  logic [NUM_REQ-1:0]      w_grant;
  logic                    w_promote;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [31:0]             w_wdata;
  logic [3:0]              w_we;
  logic                    w_rd;

  assign w_req = {bus.fetch_req, bus.data_req, bus.ocd_req};

  // Next state and which requesters may compete this cycle
  always_comb begin
    w_state_nxt = r_state;
    w_req_elig  = '0;
    case (r_state)
      ARB_NORMAL: begin
        w_req_elig = w_req;
        if (bus.ocd_lock) w_state_nxt = ARB_DRAIN;
      end
      ARB_DRAIN: begin
        w_state_nxt = ARB_LOCKED;
      end
      ARB_LOCKED: begin
        w_req_elig[REQ_OCD] = w_req[REQ_OCD];
        if (!bus.ocd_lock) w_state_nxt = ARB_NORMAL;
      end
      default: begin
        w_state_nxt = ARB_NORMAL;
      end
    endcase
    if (!reset_n) w_req_elig = '0;
  end

  mem_arb_prio_sel u_prio_sel (
    .i_req           (w_req_elig),
    .i_promote_fetch (w_promote),
    .o_grant         (w_grant)
  );

  // Winner's address/data/enables; idle cycles hold the last address
  always_comb begin
    w_addr  = r_addr_last;
    w_wdata = '0;
    w_we    = '0;
    if (w_grant[REQ_OCD]) begin
      w_addr  = bus.ocd_addr;
      w_wdata = bus.ocd_wdata;
      w_we    = bus.ocd_we;
    end else if (w_grant[REQ_DATA]) begin
      w_addr  = bus.data_addr;
      w_wdata = bus.data_wdata;
      w_we    = bus.data_we;
    end else if (w_grant[REQ_FETCH]) begin
      w_addr  = bus.fetch_addr;
    end
  end

  assign w_rd = (w_we == 4'b0000);

  assign bus.ocd_ack      = w_grant[REQ_OCD];
  assign bus.data_ack     = w_grant[REQ_DATA];
  assign bus.fetch_ack    = w_grant[REQ_FETCH];
  assign bus.mem_addr     = w_addr;
  assign bus.mem_din_high = w_wdata[31:16];
  assign bus.mem_din_low  = w_wdata[15:0];
  assign bus.mem_we_high  = w_we[3:2];
  assign bus.mem_we_low   = w_we[1:0];

  // p1: grant stage to read-return stage, aligned with the banks' registered output
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ARB_NORMAL;
      r_locked    <= 1'b0;
      r_rvalid_p1 <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_locked    <= (w_state_nxt == ARB_LOCKED);
      r_rvalid_p1 <= w_grant & {NUM_REQ{w_rd}};
    end
  end

  always_ff @(posedge clk) begin
    r_addr_last <= w_addr;
  end

  assign bus.ocd_locked   = r_locked;
  assign bus.ocd_rvalid   = r_rvalid_p1[REQ_OCD];
  assign bus.data_rvalid  = r_rvalid_p1[REQ_DATA];
  assign bus.fetch_rvalid = r_rvalid_p1[REQ_FETCH];
  assign bus.rdata        = {bus.mem_dout_high, bus.mem_dout_low};

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_starve_cnt;

  // Counts denied fetch cycles in NORMAL only; frozen while the loader owns the port
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (r_state == ARB_NORMAL) begin
      if (!bus.fetch_req || w_grant[REQ_FETCH]) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != CNT_W'(STARVE_LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

  assign w_promote = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
`else
  assign w_promote = 1'b0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, 32-bit-wide memory between three requesters: OCD/loader, data load/store, and instruction fetch.
- The memory is built as two 16-bit banks, high and low, that share one word address. Each bank has a 2-bit byte write enable and a registered read output with 1-cycle latency.
- The arbiter picks one requester per cycle, splits writes across the two banks, returns read data one cycle after grant, and sequences exclusive loader access.

Parameters:
- ADDR_WIDTH, 12, word address width of both banks.
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is promoted (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- ocd_lock  in  1  loader requests exclusive memory ownership.
- ocd_locked  out  1  exclusive ownership active.
- ocd_req / data_req / fetch_req  in  1 each  access request.
- ocd_we / data_we  in  4 each  byte enables; 0 means read. Fetch is read-only.
- ocd_addr / data_addr / fetch_addr  in  ADDR_WIDTH each  word address.
- ocd_wdata / data_wdata  in  32 each  write data.
- ocd_ack / data_ack / fetch_ack  out  1 each  request granted this cycle (combinational).
- ocd_rvalid / data_rvalid / fetch_rvalid  out  1 each  read data valid (registered).
- rdata  out  32  shared read data = {mem_dout_high, mem_dout_low}.
- mem_addr  out  ADDR_WIDTH  address to both banks.
- mem_din_high / mem_din_low  out  16 each  wdata[31:16] / wdata[15:0].
- mem_we_high / mem_we_low  out  2 each  we[3:2] / we[1:0].
- mem_dout_high / mem_dout_low  in  16 each  bank read data.

Behaviour:
- While reset_n=0 at a clock edge:
  - state <= NORMAL; all rvalid <= 0; ocd_locked <= 0; starvation counter <= 0.
  - Acks and mem_we are forced to 0 during that cycle. mem_addr and mem_din are don't-care.
- States:
  - NORMAL: fixed priority ocd > data > fetch.
  - DRAIN: no grants.
  - LOCKED: only ocd is granted.
- Transitions:
  - NORMAL to DRAIN when ocd_lock=1.
  - DRAIN to LOCKED unconditionally, after one cycle.
  - LOCKED to NORMAL when ocd_lock=0.
  - ocd_lock falling while in DRAIN: next state is still LOCKED, which then exits to NORMAL on the following cycle.
- ocd_locked = (state==LOCKED), registered.
- Grant (cycle N):
  - The winner's ack=1 combinationally, and its addr, wdata and byte enables drive the mem_* outputs that same cycle.
  - Losers get ack=0 and must hold their request.
  - With no winner: mem_we=0 and mem_addr holds its last value.
- Read (winner's we==0):
  - The winner's rvalid=1 in cycle N+1, and rdata is valid in N+1 only.
  - Back-to-back grants are allowed every cycle; rvalid for different requesters may be in flight in consecutive cycles.
- Write (winner's we!=0):
  - No rvalid.
  - Partial byte enables touch only the selected bytes. Example: we=4'b0100 drives mem_we_high=2'b01, mem_we_low=2'b00.
- Simultaneous requests: the single winner is chosen by the priority above; the others are not acked that cycle.
- Reset asserted mid-lock: returns to NORMAL. A read granted in the reset cycle produces no rvalid.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A counter (width clog2(STARVE_LIMIT+1)) increments each NORMAL cycle with fetch_req=1 and fetch_ack=0.
  - It clears when fetch_req=0 or fetch_ack=1.
  - When the count equals STARVE_LIMIT, fetch outranks data for that cycle; ocd still outranks fetch.
  - The counter holds during DRAIN/LOCKED.
- Undefined: strict ocd > data > fetch; the counter logic is absent.

Decomposition:
- Package mem_arb_pkg:
  - State enum {ARB_NORMAL, ARB_DRAIN, ARB_LOCKED}.
  - Requester-index constants REQ_OCD=0, REQ_DATA=1, REQ_FETCH=2.
  - BANK_DW=16.
- One natural sub-module, mem_arb_prio_sel: combinational priority select taking the request vector and promote-fetch flag, producing a one-hot grant.

Test Plan:
- Fetch read at addr 0 with memory preloaded to 32'h04c0006f -> fetch_ack in cycle N; fetch_rvalid in N+1 with rdata=32'h04c0006f.
- data_req and fetch_req both high, data we=0 -> data acked first; fetch acked in the next cycle; rvalids in consecutive cycles; no overlap on the wrong requester.
- data write addr 2048, we=4'b0011, wdata=32'h12345678 -> mem_we_low=2'b11, mem_we_high=0; subsequent read returns 32'hffff5678.
- ocd_lock=1 while data and fetch are continuously requesting -> one DRAIN cycle with no acks; ocd_locked=1 from cycle +2; only ocd is acked. Lock drops -> NORMAL the next cycle and data is granted.
- Guard feature defined, STARVE_LIMIT=4, data_req and fetch_req held high -> 4 data grants, then 1 fetch grant, then the counter clears. Guard undefined -> fetch is never granted.
- reset_n=0 during LOCKED with a read granted in the same cycle -> next cycle state NORMAL, ocd_locked=0, all rvalid=0.
